// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the two-port unified-memory arbiter.
package mem_arb_pkg;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        REQ_IF,
        REQ_D
    } req_id_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to whoever
// was not served last. Purely combinational.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_served,
    output logic winner
);

    always_comb begin
        winner = logic'(REQ_IF);
        if (if_req && d_req) begin
            winner = (last_served == logic'(REQ_IF)) ? logic'(REQ_D) : logic'(REQ_IF);
        end else if (d_req) begin
            winner = logic'(REQ_D);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one fixed-latency memory.
// One access at a time: IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP -> IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_id_e          win_q, win_d;
    req_id_e          last_q, last_d;
    logic             we_q, we_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             if_ack_q, if_ack_d;
    logic             d_ack_q, d_ack_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;
    logic             busy_q, busy_d;
    logic             arb_win;

    arb_rr2 u_arb (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_served (logic'(last_q)),
        .winner      (arb_win)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        last_d      = last_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d  = ISSUE;
                    win_d    = req_id_e'(arb_win);
                    last_d   = req_id_e'(arb_win);
                    mem_en_d = 1'b1;
                    if (req_id_e'(arb_win) == REQ_D) begin
                        we_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        we_d       = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = LAT_CNT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Counter hits zero this cycle: mem_rdata is valid right now.
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (win_q == REQ_IF) if_rdata_d = mem_rdata;
                        else                 d_rdata_d  = mem_rdata;
                    end
                    if_ack_d = (win_q == REQ_IF);
                    d_ack_d  = (win_q == REQ_D);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= REQ_IF;
            last_q      <= REQ_D;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            last_q      <= last_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-timeline model plus directed literal checks,
// with extra LAT=1 and LAT=15 instances for latency extremes.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata;
    logic          if_ack, d_ack, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // ---------------- latency-extreme instances (fetch only) ----------------
    logic          r1_req = 1'b0, r15_req = 1'b0;
    logic          r1_ack, r15_ack, r1_dack, r15_dack, r1_en, r15_en, r1_we, r15_we, r1_busy, r15_busy;
    logic [DW-1:0] r1_rd, r15_rd, r1_drd, r15_drd, r1_wd, r15_wd, r1_mrd, r15_mrd;
    logic [AW-1:0] r1_ma, r15_ma;
    int            r1_due = -1, r15_due = -1, r1_en_n = 0, r15_en_n = 0, r1_ack_cyc = -1, r15_ack_cyc = -1;

    assign r1_mrd  = (cyc == r1_due)  ? 32'hC0DE_0001 : 32'h0;
    assign r15_mrd = (cyc == r15_due) ? 32'hC0DE_000F : 32'h0;

    mem_arbiter #(.LAT(1), .AW(AW), .DW(DW)) dut1 (
        .clk(clk), .rst(rst), .if_req(r1_req), .if_addr(32'h80), .if_ack(r1_ack),
        .if_rdata(r1_rd), .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(r1_dack), .d_rdata(r1_drd), .mem_en(r1_en), .mem_we(r1_we),
        .mem_addr(r1_ma), .mem_wdata(r1_wd), .mem_rdata(r1_mrd), .busy(r1_busy)
    );

    mem_arbiter #(.LAT(15), .AW(AW), .DW(DW)) dut15 (
        .clk(clk), .rst(rst), .if_req(r15_req), .if_addr(32'h84), .if_ack(r15_ack),
        .if_rdata(r15_rd), .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(r15_dack), .d_rdata(r15_drd), .mem_en(r15_en), .mem_we(r15_we),
        .mem_addr(r15_ma), .mem_wdata(r15_wd), .mem_rdata(r15_mrd), .busy(r15_busy)
    );

    always @(negedge clk) begin
        if (r1_en)  begin r1_en_n++;  r1_due  = cyc + 1;  end
        if (r15_en) begin r15_en_n++; r15_due = cyc + 15; end
        if (r1_ack)  r1_ack_cyc  = cyc;
        if (r15_ack) r15_ack_cyc = cyc;
    end

    // ---------------- memory for the main instance ----------------
    logic [DW-1:0] mem [int unsigned];
    int            rd_due = -1;
    logic [DW-1:0] rd_val = '0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = {a[15:0], 16'h5A5A};
        if (mem.exists(a)) v = mem[a];
        return v;
    endfunction

    // Read data is valid only in the one cycle LAT after the strobe; junk otherwise.
    assign mem_rdata = (cyc == rd_due) ? rd_val : (32'hBAD0_0000 ^ DW'(cyc));

    always @(negedge clk) begin
        if (mem_en && !rst) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
                rd_due = cyc + LAT;
                rd_val = mem_rd(mem_addr);
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: an access granted in cycle s strobes at s+1, acks at
    // s+2+LAT, and the block is idle again (may grant) at s+3+LAT.
    bit            m_act = 0, m_win = 0, m_last = 1, m_we = 0;
    int            m_s = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_data = '0, m_if_rd = '0, m_d_rd = '0;

    always @(negedge clk) begin
        int k;
        if (rst) begin
            m_act = 0; m_last = 1; m_if_rd = '0; m_d_rd = '0;
            chk("rst_mem_en", mem_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_acks", {if_ack, d_ack}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_rdata", {if_rdata, d_rdata}, 0);
        end else begin
            k = m_act ? cyc - m_s : -1;
            if (m_act && k == 3 + LAT) m_act = 0;
            chk("mem_en", mem_en, m_act && k == 1);
            if (m_act && k == 1) begin
                chk("mem_we", mem_we, m_we);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_act && k >= 1) chk("mem_addr", mem_addr, m_addr);
            chk("busy", busy, m_act && k >= 1);
            chk("if_ack", if_ack, m_act && k == 2 + LAT && !m_win);
            chk("d_ack", d_ack, m_act && k == 2 + LAT && m_win);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("d_rdata", d_rdata, m_d_rd);
            if (m_act && k == 1 + LAT && !m_we) begin
                if (m_win) m_d_rd = m_data;
                else       m_if_rd = m_data;
            end
            if (!m_act && (if_req || d_req)) begin
                m_win   = (if_req && d_req) ? !m_last : d_req;
                m_last  = m_win;
                m_act   = 1;
                m_s     = cyc;
                m_we    = m_win ? d_we : 1'b0;
                m_addr  = m_win ? d_addr : if_addr;
                m_wdata = d_wdata;
                m_data  = mem_rd(m_addr);
            end
        end
    end

    int            if_ack_q[$], d_ack_q[$], en_q[$];
    logic [AW-1:0] en_addr;
    logic          en_we;
    logic [DW-1:0] en_wdata;

    always @(negedge clk) begin
        if (if_ack) if_ack_q.push_back(cyc);
        if (d_ack)  d_ack_q.push_back(cyc);
        if (mem_en) begin
            en_q.push_back(cyc);
            en_addr  = mem_addr;
            en_we    = mem_we;
            en_wdata = mem_wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        if_ack_q.delete(); d_ack_q.delete(); en_q.delete();
    endtask

    // One access from idle; optionally drops req right after C0. Returns C0.
    task automatic access(input bit is_d, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit drop_early, output int t0);
        bit ok;
        clear_q();
        tick();
        t0 = cyc;
        if (is_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else      begin if_req = 1; if_addr = a; end
        if (drop_early) begin tick(); if_req = 0; d_req = 0; end
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = is_d ? d_ack : if_ack;
        end
        chk("ack_timeout", ok, 1);
        tick();
        if_req = 0; d_req = 0; d_we = 0;
    endtask

    initial begin
        int  t0;
        bit  ok;
        mem[32'h40] = 32'h8C01_0004;
        tick(); tick();
        chk("rst_lit_busy", busy, 0);
        chk("rst_lit_mem_en", mem_en, 0);
        chk("rst_lit_if_rdata", if_rdata, 0);
        rst = 0;

        // Fetch only.
        access(0, 0, 32'h40, 0, 0, t0);
        chk("f_en_cyc", en_q[0] - t0, 1);
        chk("f_en_addr", en_addr, 32'h40);
        chk("f_ack_cyc", if_ack_q[0] - t0, 4);
        chk("f_rdata", if_rdata, 32'h8C01_0004);
        @(negedge clk);
        chk("f_busy_c5", busy, 0);

        // Load, then store (d_rdata must not move), then load back the stored word.
        access(1, 0, 32'h200, 0, 0, t0);
        chk("ld_rdata", d_rdata, 32'h0200_5A5A);
        access(1, 1, 32'h100, 32'hDEAD_BEEF, 0, t0);
        chk("st_en_cyc", en_q[0] - t0, 1);
        chk("st_en_we", en_we, 1);
        chk("st_en_addr", en_addr, 32'h100);
        chk("st_en_wdata", en_wdata, 32'hDEAD_BEEF);
        chk("st_ack_cyc", d_ack_q[0] - t0, 4);
        chk("st_rdata_kept", d_rdata, 32'h0200_5A5A);
        access(1, 0, 32'h100, 0, 0, t0);
        chk("ld_back", d_rdata, 32'hDEAD_BEEF);

        // Fetch whose request drops after C0 still completes.
        access(0, 0, 32'h48, 0, 1, t0);
        chk("drop_ack_cyc", if_ack_q[0] - t0, 4);
        chk("drop_rdata", if_rdata, 32'h0048_5A5A);

        // Reset in C2 of a load aborts it with no ack.
        clear_q();
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h208;
        tick(); tick();
        rst = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_d_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        rst = 0;
        repeat (6) tick();
        chk("abort_no_ack", d_ack_q.size(), 0);
        access(1, 0, 32'h208, 0, 0, t0);
        chk("reissue_ack_cyc", d_ack_q[0] - t0, 4);
        chk("reissue_rdata", d_rdata, 32'h0208_5A5A);

        // Both held: fetch, data, fetch.
        clear_q();
        tick();
        t0 = cyc;
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h300;
        repeat (15) tick();
        if_req = 0; d_req = 0;
        tick();
        chk("rr_if_ack0", if_ack_q[0] - t0, 4);
        chk("rr_d_en", en_q[1] - t0, 6);
        chk("rr_d_ack", d_ack_q[0] - t0, 9);
        chk("rr_if_ack1", if_ack_q[1] - t0, 14);
        chk("rr_d_rdata", d_rdata, 32'h0300_5A5A);

        // Latency extremes, requests dropped after C0.
        tick();
        t0 = cyc;
        r1_req = 1; r15_req = 1;
        tick();
        r1_req = 0; r15_req = 0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = r15_ack;
        end
        chk("lat15_timeout", ok, 1);
        tick(); tick();
        chk("lat1_ack_cyc", r1_ack_cyc - t0, 3);
        chk("lat15_ack_cyc", r15_ack_cyc - t0, 17);
        chk("lat1_en_n", r1_en_n, 1);
        chk("lat15_en_n", r15_en_n, 1);
        chk("lat1_rdata", r1_rd, 32'hC0DE_0001);
        chk("lat15_rdata", r15_rd, 32'hC0DE_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2: memory read latency in cycles, from the mem_en cycle to mem_rdata valid; legal range 1..15.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 if_req  input  1  instruction-fetch request; held high until if_ack.
REQ-007 if_addr  input  AW  fetch address; stable while if_req is high.
REQ-008 if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-009 if_rdata  output  DW  fetched instruction word.
REQ-010 d_req  input  1  data request; held high until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load; stable while d_req is high.
REQ-012 d_addr  input  AW  data address.
REQ-013 d_wdata  input  DW  store data.
REQ-014 d_ack  output  1  one-cycle pulse: data access complete.
REQ-015 d_rdata  output  DW  load data; valid with d_ack when d_we = 0.
REQ-016 mem_en  output  1  single-cycle access strobe to the unified memory.
REQ-017 mem_we  output  1  write enable; qualified by mem_en.
REQ-018 mem_addr  output  AW  memory address; held from ISSUE through RESP.
REQ-019 mem_wdata  output  DW  memory write data.
REQ-020 mem_rdata  input  DW  memory read data, valid exactly LAT cycles after the mem_en cycle.
REQ-021 busy  output  1  high in every state other than IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with all outputs registered.
REQ-023 IDLE SHALL go to ISSUE when any request is high, latching winner, address, we and wdata; otherwise it SHALL stay in IDLE.
REQ-024 Arbitration SHALL work as follows:
- single request: that requester wins;
- both requests: the requester not served last wins (round-robin);
- the last-served pointer updates on each grant.
REQ-025 ISSUE SHALL last exactly 1 cycle with mem_en = 1, load the counter with LAT, and go to WAIT.
REQ-026 WAIT SHALL decrement the counter each cycle; on reaching 0 it SHALL capture mem_rdata (loads only) and go to RESP.
REQ-027 RESP SHALL pulse the winner's ack for 1 cycle and then go to IDLE; RESP SHALL NOT sample requests.
REQ-028 Timing SHALL be as follows, with C0 the IDLE cycle that samples a request:
- mem_en in C1;
- mem_rdata captured at the end of C(1+LAT);
- ack in C(2+LAT);
- IDLE in C(3+LAT).
REQ-029 if_rdata and d_rdata SHALL each hold their last loaded value; stores SHALL NOT modify d_rdata.
REQ-030 Requests sampled while busy SHALL be ignored, not queued; a requester whose req is still high in IDLE is re-arbitrated.
REQ-031 A request that drops before its ack SHALL NOT abort an access in progress, and the ack SHALL still be issued.
REQ-032 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-033 While rst is high, the block SHALL be in IDLE with mem_en, mem_we, if_ack, d_ack and busy at 0.
REQ-034 While rst is high, mem_addr, mem_wdata, if_rdata, d_rdata and the counter SHALL be 0, and the last-served pointer SHALL be "data" so that fetch wins the first tie.
REQ-035 rst asserted mid-access SHALL abort the access immediately with no ack; a write already strobed by mem_en is not undone.

Structure
REQ-036 A shared package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP), the requester-id enum (REQ_IF, REQ_D), and LAT_MAX = 15.
REQ-037 The round-robin pick SHALL be one sub-module, arb_rr2, taking the two requests and the last-served pointer and returning the winner id; it is purely combinational.
REQ-038 The counter width SHALL be $clog2(LAT_MAX+1).

Verification
REQ-039 LAT=2, fetch only (if_req with if_addr=0x40; memory returns 0x8C010004): mem_en in C1 with mem_addr=0x40, if_ack in C4 with if_rdata=0x8C010004, busy low in C5.
REQ-040 Both requests high from C0, held: fetch served first (acked C4), data served second (mem_en C6, d_ack C9), then fetch again.
REQ-041 Store with d_addr=0x100 and d_wdata=0xDEADBEEF: mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF in C1; d_ack in C4; d_rdata unchanged.
REQ-042 rst pulsed in C2 of a load: outputs zero immediately, no d_ack, IDLE; re-requesting afterwards completes normally.
REQ-043 LAT=1 and LAT=15: ack arrives in C3 and C17 respectively, with exactly one mem_en pulse per access.
